// File: rtl/accel_pkg.sv
// accel_pkg: shared FSM state encoding, width defaults and a burst-length clamp for the accelerator blocks
package accel_pkg;
  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, RESULT} state_t;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_ACC_W = 32;
  localparam int DEF_MAX_LEN = 16;
  function automatic int clamp_len(input int l, input int max_len);
    return l > max_len ? max_len : l;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick; ports: req vector and last-winner ptr in, one-hot grant and its idx out
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);
  logic [IW-1:0] k;
  always_comb begin
    grant = '0;
    idx = '0;
    k = '0;
    for (int i = N; i >= 1; i--) begin
      k = IW'((int'(ptr) + i) % N);
      if (req[k]) begin
        grant = '0;
        grant[k] = 1'b1;
        idx = k;
      end
    end
  end
endmodule

// File: rtl/mac_scheduler.sv
// mac_scheduler: round-robin sharing of one mac_unit; ports: req/req_len/op_a/op_b/op_valid in and op_ready/gnt/res_valid out per requester, res_data out, mac_a/mac_b/mac_en/mac_rst to and mac_acc from the mac_unit, busy out
module mac_scheduler
  import accel_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W = DEF_ACC_W,
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int LEN_W = 5,
  parameter int MAC_LAT = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*LEN_W-1:0]   req_len,
  input  logic [NUM_REQ*DATA_W-1:0]  op_a,
  input  logic [NUM_REQ*DATA_W-1:0]  op_b,
  input  logic [NUM_REQ-1:0]         op_valid,
  output logic [NUM_REQ-1:0]         op_ready,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [NUM_REQ-1:0]         res_valid,
  output logic [ACC_W-1:0]           res_data,
  output logic [DATA_W-1:0]          mac_a,
  output logic [DATA_W-1:0]          mac_b,
  output logic                       mac_en,
  output logic                       mac_rst,
  input  logic [ACC_W-1:0]           mac_acc,
  output logic                       busy
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int DW = $clog2(MAC_LAT + 1) + 1;
  state_t state, state_n;
  logic [IW-1:0] ptr, w, widx, ptr_d, w_d;
  logic [NUM_REQ-1:0] win, gnt_d, res_valid_d;
  logic [LEN_W-1:0] len, count, rlen, len_d, count_d;
  logic [DW-1:0] dcnt, dcnt_d;
  logic [ACC_W-1:0] res_data_d;
  logic [DATA_W-1:0] mac_a_d, mac_b_d;
  logic accept, last, drained, mac_en_d, mac_rst_d, busy_d;
  rr_arbiter #(.N(NUM_REQ)) u_arb (.req(req), .ptr(ptr), .grant(win), .idx(widx));
  assign rlen = req_len[widx*LEN_W +: LEN_W];
  assign accept = state == FEED && op_valid[w];
  assign last = accept && count + LEN_W'(1) == len;
  // DRAIN spans MAC_LAT+1 cycles: one for the operand register, MAC_LAT inside the mac_unit
  assign drained = state == DRAIN && dcnt == DW'(MAC_LAT);
  assign op_ready = state == FEED ? gnt : '0;
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      ptr <= IW'(NUM_REQ - 1);
      w <= '0;
      len <= '0;
      count <= '0;
      dcnt <= '0;
      gnt <= '0;
      res_valid <= '0;
      res_data <= '0;
      mac_a <= '0;
      mac_b <= '0;
      mac_en <= 1'b0;
      mac_rst <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      ptr <= ptr_d;
      w <= w_d;
      len <= len_d;
      count <= count_d;
      dcnt <= dcnt_d;
      gnt <= gnt_d;
      res_valid <= res_valid_d;
      res_data <= res_data_d;
      mac_a <= mac_a_d;
      mac_b <= mac_b_d;
      mac_en <= mac_en_d;
      mac_rst <= mac_rst_d;
      busy <= busy_d;
    end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = |req ? CLEAR : IDLE;
      CLEAR:   state_n = len == '0 ? DRAIN : FEED;
      FEED:    state_n = last ? DRAIN : FEED;
      DRAIN:   state_n = drained ? RESULT : DRAIN;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    gnt_d = state_n == IDLE ? '0 : state == IDLE ? win : gnt;
    w_d = state == IDLE ? widx : w;
    len_d = state == IDLE ? LEN_W'(clamp_len(int'(rlen), MAX_LEN)) : len;
    count_d = state == CLEAR ? '0 : accept ? count + LEN_W'(1) : count;
    dcnt_d = state == DRAIN ? dcnt + DW'(1) : '0;
    mac_a_d = accept ? op_a[w*DATA_W +: DATA_W] : mac_a;
    mac_b_d = accept ? op_b[w*DATA_W +: DATA_W] : mac_b;
    mac_en_d = accept;
    mac_rst_d = state_n == CLEAR;
    res_valid_d = drained ? gnt : '0;
    res_data_d = drained ? mac_acc : res_data;
    ptr_d = state == RESULT ? w : ptr;
    busy_d = state_n != IDLE;
  end
endmodule

// File: tb/tb_mac_scheduler.sv
// tb_mac_scheduler: scoreboard bench for mac_scheduler with a behavioural mac_unit and requester drivers
module tb_mac_scheduler;
  localparam int NR = 4;
  localparam int DW = 16;
  localparam int AW = 32;
  localparam int LW = 5;
  typedef struct {int idx; logic [AW-1:0] data; int cyc;} exp_t;
  logic clk = 1'b0;
  logic rst;
  logic [NR-1:0] req, op_valid, op_ready, gnt, res_valid;
  logic [NR*LW-1:0] req_len;
  logic [NR*DW-1:0] op_a, op_b;
  logic [AW-1:0] res_data, mac_acc;
  logic [DW-1:0] mac_a, mac_b;
  logic mac_en, mac_rst, busy;
  exp_t sb[$];
  logic [DW-1:0] qa[NR][$];
  logic [DW-1:0] qb[NR][$];
  bit vpat[NR][$];
  logic [AW-1:0] exp_data[NR];
  logic [NR-1:0] pending = '0;
  bit drop_early[NR];
  int mptr = NR - 1;
  int vprob = 100;
  int vectors = 0;
  int errs = 0;
  int cyc = 0;
  int en_cnt = 0;
  int acc_cnt = 0;
  logic prev_acc = 1'b0;
  logic [DW-1:0] prev_a, prev_b;
  logic signed [AW-1:0] prod, acc_m;
  logic pv;

  mac_scheduler dut (
    .clk(clk), .rst(rst), .req(req), .req_len(req_len), .op_a(op_a), .op_b(op_b),
    .op_valid(op_valid), .op_ready(op_ready), .gnt(gnt), .res_valid(res_valid),
    .res_data(res_data), .mac_a(mac_a), .mac_b(mac_b), .mac_en(mac_en),
    .mac_rst(mac_rst), .mac_acc(mac_acc), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // behavioural mac_unit: product registered on an enabled edge, accumulated on the next one
  always @(posedge clk) begin
    if (rst || mac_rst) begin
      pv <= 1'b0;
      prod <= '0;
      acc_m <= '0;
    end else begin
      pv <= mac_en;
      prod <= $signed({{16{mac_a[15]}}, mac_a}) * $signed({{16{mac_b[15]}}, mac_b});
      if (pv) acc_m <= acc_m + prod;
    end
  end
  assign mac_acc = acc_m;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  always @(negedge clk) begin
    exp_t e;
    chk("gnt_onehot", 64'($onehot0(gnt)), 64'd1);
    chk("busy_vs_gnt", 64'(busy), 64'(|gnt));
    chk("ready_in_gnt", 64'(op_ready & ~gnt), 64'd0);
    chk("rst_en_excl", 64'(mac_rst & mac_en), 64'd0);
    chk("mac_en", 64'(mac_en), 64'(prev_acc));
    if (mac_en) begin
      chk("mac_a", 64'(mac_a), 64'(prev_a));
      chk("mac_b", 64'(mac_b), 64'(prev_b));
      en_cnt++;
    end
    if (gnt != '0) begin
      if (sb.size() > 0) chk("gnt", 64'(gnt), 64'(1) << sb[0].idx);
      else chk("spurious_gnt", 64'(gnt), 64'd0);
    end
    if (res_valid != '0) begin
      if (sb.size() == 0) chk("spurious_res_valid", 64'(res_valid), 64'd0);
      else begin
        e = sb.pop_front();
        chk("res_valid_idx", 64'(res_valid), 64'(1) << e.idx);
        chk("res_data", 64'(res_data), 64'(e.data));
        if (e.cyc >= 0) chk("latency", 64'(cyc), 64'(e.cyc));
      end
    end
    prev_acc = |(op_ready & op_valid) && !rst;
    for (int i = 0; i < NR; i++)
      if (op_ready[i] && op_valid[i]) begin
        prev_a = op_a[i*DW +: DW];
        prev_b = op_b[i*DW +: DW];
      end
  end

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      req[i] = pending[i];
      if (qa[i].size() == 0) op_valid[i] = 1'b0;
      else if (op_ready[i] && vpat[i].size() > 0) op_valid[i] = vpat[i].pop_front();
      else op_valid[i] = $urandom_range(99) < vprob;
      op_a[i*DW +: DW] = qa[i].size() > 0 ? qa[i][0] : 16'($urandom);
      op_b[i*DW +: DW] = qb[i].size() > 0 ? qb[i][0] : 16'($urandom);
    end
  endtask

  task automatic cycle();
    logic [NR-1:0] a;
    @(negedge clk);
    a = op_ready & op_valid;
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (a[i] && qa[i].size() > 0) begin
        qa[i].delete(0);
        qb[i].delete(0);
        acc_cnt++;
      end
      if (res_valid[i]) begin
        pending[i] = 1'b0;
        qa[i].delete();
        qb[i].delete();
        vpat[i].delete();
      end
      if (drop_early[i] && op_ready[i]) begin
        pending[i] = 1'b0;
        drop_early[i] = 1'b0;
      end
    end
    drive();
  endtask

  task automatic check_zero(input string name);
    chk(name, 64'({gnt, op_ready, res_valid, mac_en, mac_rst, mac_a, mac_b, busy}), 64'd0);
    chk({name, "_res_data"}, 64'(res_data), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    check_zero("reset_outputs");
    rst = 1'b0;
    sb.delete();
    pending = '0;
    mptr = NR - 1;
    for (int i = 0; i < NR; i++) begin
      qa[i].delete();
      qb[i].delete();
      vpat[i].delete();
      drop_early[i] = 1'b0;
    end
    drive();
  endtask

  task automatic fill(input int r, input int n);
    for (int k = 0; k < n; k++) begin
      qa[r].push_back($urandom_range(7) == 0 ? 16'h8000 : 16'($urandom));
      qb[r].push_back($urandom_range(7) == 0 ? 16'hffff : 16'($urandom));
    end
  endtask

  task automatic set_burst(input int r, input int len);
    longint s = 0;
    int n = len > 16 ? 16 : len;
    for (int k = 0; k < n; k++) s += longint'($signed(qa[r][k])) * longint'($signed(qb[r][k]));
    exp_data[r] = s[31:0];
    req_len[r*LW +: LW] = LW'(len);
  endtask

  // all requesters in mask are presented together to an idle scheduler
  task automatic launch(input logic [NR-1:0] mask, input int lat);
    logic [NR-1:0] m = mask;
    int p = mptr;
    while (m != '0) begin
      for (int k = 1; k <= NR; k++) begin
        int c;
        c = (p + k) % NR;
        if (m[c]) begin
          sb.push_back('{c, exp_data[c], lat < 0 ? -1 : cyc + lat + 1});
          m[c] = 1'b0;
          p = c;
          break;
        end
      end
    end
    mptr = p;
    pending = pending | mask;
    req = pending;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while ((sb.size() != 0 || busy) && n < budget) begin
      cycle();
      n++;
    end
    if (n >= budget) begin
      chk("timeout_pending_results", 64'(sb.size()), 64'd0);
      do_reset();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] bub_a[3] = '{16'd2, 16'd4, 16'd6};
    logic [15:0] bub_b[3] = '{16'd3, 16'd5, 16'd7};
    int n;
    rst = 1'b1;
    req = '0;
    req_len = '0;
    op_a = '0;
    op_b = '0;
    op_valid = '0;
    cycle();
    do_reset();
    for (int r = 0; r < NR; r++) begin
      qa[r].push_back(16'd1);
      qb[r].push_back(16'd1);
      set_burst(r, 1);
    end
    launch(4'b1111, -1);
    wait_done(500);
    for (int k = 1; k <= 9; k++) begin
      qa[0].push_back(16'(k));
      qb[0].push_back(k <= 3 ? 16'hffff : k <= 6 ? 16'd0 : 16'd1);
    end
    set_burst(0, 9);
    launch(4'b0001, 13);
    wait_done(500);
    for (int k = 0; k < 3; k++) begin
      qa[3].push_back(bub_a[k]);
      qb[3].push_back(bub_b[k]);
    end
    vpat[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    set_burst(3, 3);
    en_cnt = 0;
    launch(4'b1000, 9);
    wait_done(500);
    chk("bubble_mac_en_count", 64'(en_cnt), 64'd3);
    set_burst(1, 0);
    en_cnt = 0;
    launch(4'b0010, 4);
    wait_done(500);
    chk("len0_mac_en_count", 64'(en_cnt), 64'd0);
    fill(2, 20);
    set_burst(2, 20);
    en_cnt = 0;
    launch(4'b0100, 20);
    wait_done(500);
    chk("clamp_mac_en_count", 64'(en_cnt), 64'd16);
    qa[0] = '{16'h8000, 16'h8000};
    qb[0] = '{16'hffff, 16'hffff};
    set_burst(0, 2);
    launch(4'b0001, 6);
    wait_done(500);
    vprob = 60;
    fill(1, 5);
    fill(2, 3);
    set_burst(1, 5);
    set_burst(2, 3);
    drop_early[1] = 1'b1;
    launch(4'b0110, -1);
    wait_done(500);
    vprob = 100;
    fill(0, 9);
    set_burst(0, 9);
    launch(4'b0001, -1);
    acc_cnt = 0;
    n = 0;
    while (acc_cnt < 4 && n < 50) begin
      cycle();
      n++;
    end
    chk("midfeed_accepts", 64'(acc_cnt), 64'd4);
    do_reset();
    repeat (20) cycle();
    fill(2, 6);
    set_burst(2, 6);
    launch(4'b0100, 10);
    wait_done(500);
    for (int round = 0; round < 25; round++) begin
      logic [NR-1:0] mask;
      mask = NR'($urandom_range(1, 15));
      vprob = $urandom_range(40, 100);
      for (int r = 0; r < NR; r++)
        if (mask[r]) begin
          int len;
          len = $urandom_range(0, 20);
          fill(r, len);
          set_burst(r, len);
        end else req_len[r*LW +: LW] = LW'($urandom);
      launch(mask, -1);
      wait_done(3000);
    end
    repeat (4) cycle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
